// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score path (score_keeper, bcd_counter2).
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned DEFAULT_UNIT_FRAMES = 30;
  localparam bcd_t        BCD_MAX             = 4'd9;

endpackage

// File: rtl/score_keeper_bcd_counter2.sv
// Two-digit BCD counter with parallel binary value, clear, enable and a
// saturation limit; 'incremented' pulses in the cycle the new value appears.
module bcd_counter2
  import score_pkg::*;
#(
  parameter int unsigned MAX_VALUE = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output bcd_t       digit_hi,
  output bcd_t       digit_lo,
  output logic [6:0] value,
  output logic       incremented,
  output logic       at_max
);

  localparam logic [6:0] MAX_BIN = 7'(MAX_VALUE);

  assign at_max = (value == MAX_BIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_hi    <= '0;
      digit_lo    <= '0;
      value       <= '0;
      incremented <= 1'b0;
    end else if (clr) begin
      digit_hi    <= '0;
      digit_lo    <= '0;
      value       <= '0;
      incremented <= 1'b0;
    end else begin
      incremented <= 1'b0;
      if (en && !at_max) begin
        value       <= value + 7'd1;
        incremented <= 1'b1;
        if (digit_lo == BCD_MAX) begin
          digit_lo <= '0;
          digit_hi <= digit_hi + 4'd1;
        end else begin
          digit_lo <= digit_lo + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Frame-counting score keeper: VS synchroniser, frame divider and run FSM.
// Optional best-score registers enabled by SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned UNIT_FRAMES = DEFAULT_UNIT_FRAMES,
  parameter int unsigned MAX_SCORE   = 99
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       VGA_VS,
  input  logic       start,
  input  logic       collision,
  input  logic       pause,
  output logic [3:0] digit_hi,
  output logic [3:0] digit_lo,
  output logic [6:0] score_bin,
  output logic       score_tick,
  output logic       running,
  output logic       game_over,
  output logic       score_max,
  output logic [3:0] high_hi,
  output logic [3:0] high_lo
);

  localparam logic [7:0] DIV_LAST = 8'(UNIT_FRAMES - 1);

  state_t     state;
  logic       vs_s1, vs_s2, vs_prev;
  logic       frame_pulse;
  logic [7:0] divider;
  logic       cnt_clr, cnt_en;

  assign frame_pulse = vs_s2 & ~vs_prev;
  assign running     = (state == RUN);
  assign game_over   = (state == OVER);

  // Collision has priority over a coincident frame pulse, so it masks the increment.
  assign cnt_clr = start && (state != RUN);
  assign cnt_en  = running && !collision && frame_pulse && !pause && (divider == DIV_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_prev <= 1'b0;
      state   <= IDLE;
      divider <= '0;
    end else begin
      vs_s1   <= VGA_VS;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            divider <= '0;
          end
        end
        RUN: begin
          if (collision) begin
            state <= OVER;
          end else if (frame_pulse && !pause) begin
            divider <= (divider == DIV_LAST) ? '0 : divider + 8'd1;
          end
        end
        OVER: begin
          if (start) begin
            state   <= RUN;
            divider <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bcd_counter2 #(
    .MAX_VALUE(MAX_SCORE)
  ) u_counter (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .digit_hi   (digit_hi),
    .digit_lo   (digit_lo),
    .value      (score_bin),
    .incremented(score_tick),
    .at_max     (score_max)
  );

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [6:0] best_bin;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      best_bin <= '0;
      high_hi  <= '0;
      high_lo  <= '0;
    end else if (running && collision && (score_bin > best_bin)) begin
      best_bin <= score_bin;
      high_hi  <= digit_hi;
      high_lo  <= digit_lo;
    end
  end
`else
  assign high_hi = '0;
  assign high_lo = '0;
`endif

endmodule
